// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ready port between the fetch stage (master) and instruction memory (slave).
interface if_fetch_stage_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ready;
   logic [DATA_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, req/ready imem port, redirect priority and IF/ID flush.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_fetch_stage #(
   parameter int               ADDR_W    = 32,
   parameter int               DATA_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              pc_stall_i,
   input  logic              jump_i,
   input  logic [ADDR_W-1:0] jump_target_i,
   input  logic              branch_taken_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   if_fetch_stage_if.master  imem,
   output logic [ADDR_W-1:0] pc_plus4_o,
   output logic [DATA_W-1:0] instr_o,
   output logic              fetch_valid_o,
   output logic              if_flush_o
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetch_cnt_o,
   output logic [31:0]       perf_stall_cnt_o,
   output logic [31:0]       perf_flush_cnt_o
`endif
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t            state_reg;
   logic [ADDR_W-1:0] pc_reg;
   logic [ADDR_W-1:0] pend_reg;

   logic              jump_eff;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_target;
   logic [ADDR_W-1:0] pc_plus4;
   logic              deliver;

   // A jump under stall is dropped: ID holds the jump and re-asserts it once the stall clears.
   assign jump_eff        = jump_i & ~pc_stall_i;
   assign redirect        = branch_taken_i | jump_eff;
   assign redirect_target = branch_taken_i ? branch_target_i : jump_target_i;
   assign pc_plus4        = pc_reg + ADDR_W'(4);
   assign deliver         = rst_i & imem.imem_ready & (state_reg != ST_DRAIN);

   assign imem.imem_req  = rst_i;
   assign imem.imem_addr = rst_i ? pc_reg : '0;
   assign fetch_valid_o  = deliver;
   assign instr_o        = deliver ? imem.imem_rdata : NOP_INSTR;
   assign pc_plus4_o     = rst_i ? pc_plus4 : '0;
   assign if_flush_o     = rst_i & redirect;

   // The address must stay put until the outstanding access completes, so redirects
   // that arrive while the memory is busy are parked in pend_reg and applied in DRAIN.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg <= ST_FETCH;
         pc_reg    <= RESET_PC;
         pend_reg  <= '0;
      end else begin
         case (state_reg)
            ST_FETCH, ST_WAIT: begin
               if (imem.imem_ready) begin
                  state_reg <= ST_FETCH;
                  if (redirect)
                     pc_reg <= redirect_target;
                  else if (!pc_stall_i)
                     pc_reg <= pc_plus4;
               end else if (redirect) begin
                  pend_reg  <= redirect_target;
                  state_reg <= ST_DRAIN;
               end else begin
                  state_reg <= ST_WAIT;
               end
            end
            ST_DRAIN: begin
               if (branch_taken_i)
                  pend_reg <= branch_target_i;
               if (imem.imem_ready) begin
                  pc_reg    <= branch_taken_i ? branch_target_i : pend_reg;
                  state_reg <= ST_FETCH;
               end
            end
            default: begin
               state_reg <= ST_FETCH;
            end
         endcase
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [2:0]  perf_inc;
   logic [95:0] perf_cnt_flat;

   assign perf_inc = {if_flush_o, (pc_stall_i | ~imem.imem_ready), fetch_valid_o};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_perf
         logic [31:0] cnt_reg;
         always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i)
               cnt_reg <= '0;
            else if (perf_inc[gi])
               cnt_reg <= cnt_reg + 32'd1;
         end
         assign perf_cnt_flat[gi*32 +: 32] = cnt_reg;
      end
   endgenerate

   assign perf_fetch_cnt_o = perf_cnt_flat[31:0];
   assign perf_stall_cnt_o = perf_cnt_flat[63:32];
   assign perf_flush_cnt_o = perf_cnt_flat[95:64];
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: table-driven cycle vectors with a scoreboard queue,
// plus hand-written reset sequences.
module tb_if_fetch_stage;
   localparam int          ADDR_W = 32;
   localparam int          DATA_W = 32;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int          NVEC   = 32;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b0;
   logic              pc_stall_i = 1'b0;
   logic              jump_i = 1'b0;
   logic [ADDR_W-1:0] jump_target_i = '0;
   logic              branch_taken_i = 1'b0;
   logic [ADDR_W-1:0] branch_target_i = '0;
   logic [ADDR_W-1:0] pc_plus4_o;
   logic [DATA_W-1:0] instr_o;
   logic              fetch_valid_o;
   logic              if_flush_o;

   if_fetch_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) imem_bus ();

   if_fetch_stage #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .RESET_PC (32'h0000_0000),
      .NOP_INSTR(NOP)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .pc_stall_i     (pc_stall_i),
      .jump_i         (jump_i),
      .jump_target_i  (jump_target_i),
      .branch_taken_i (branch_taken_i),
      .branch_target_i(branch_target_i),
      .imem           (imem_bus.master),
      .pc_plus4_o     (pc_plus4_o),
      .instr_o        (instr_o),
      .fetch_valid_o  (fetch_valid_o),
      .if_flush_o     (if_flush_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        stall;
      logic        jump;
      logic [31:0] jt;
      logic        br;
      logic [31:0] bt;
      logic        rdy;
      logic [31:0] exp_addr;
      logic        exp_valid;
      logic        exp_flush;
   } vec_t;

   typedef struct {
      int          idx;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        flush;
   } exp_t;

   vec_t vecs [NVEC];
   exp_t sb_q [$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic vec_t mk(logic stall, logic jump, logic [31:0] jt, logic br, logic [31:0] bt,
                               logic rdy, logic [31:0] addr, logic valid, logic flush);
      vec_t v;
      v.stall = stall; v.jump = jump; v.jt = jt; v.br = br; v.bt = bt; v.rdy = rdy;
      v.exp_addr = addr; v.exp_valid = valid; v.exp_flush = flush;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk_i) begin : sb_check
      exp_t e;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check($sformatf("v%0d req", e.idx), 32'(imem_bus.imem_req), 32'd1);
         check($sformatf("v%0d addr", e.idx), imem_bus.imem_addr, e.addr);
         check($sformatf("v%0d valid", e.idx), 32'(fetch_valid_o), 32'(e.valid));
         check($sformatf("v%0d instr", e.idx), instr_o, e.instr);
         check($sformatf("v%0d flush", e.idx), 32'(if_flush_o), 32'(e.flush));
         if (e.valid)
            check($sformatf("v%0d pc4", e.idx), pc_plus4_o, e.pc4);
         $display("v%0d addr=%h valid=%0b instr=%h flush=%0b", e.idx, imem_bus.imem_addr,
                  fetch_valid_o, instr_o, if_flush_o);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      logic [31:0] rdata;

      // stall, jump, jt, br, bt, rdy, exp_addr, exp_valid, exp_flush
      vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,   1, 32'h0000_0000, 1, 0);
      vecs[1]  = mk(0, 0, 32'h0,        0, 32'h0,   1, 32'h0000_0004, 1, 0);
      vecs[2]  = mk(1, 0, 32'h0,        0, 32'h0,   1, 32'h0000_0008, 1, 0);
      vecs[3]  = mk(1, 0, 32'h0,        0, 32'h0,   1, 32'h0000_0008, 1, 0);
      vecs[4]  = mk(0, 0, 32'h0,        0, 32'h0,   1, 32'h0000_0008, 1, 0);
      vecs[5]  = mk(0, 0, 32'h0,        0, 32'h0,   1, 32'h0000_000C, 1, 0);
      vecs[6]  = mk(0, 0, 32'h0,        0, 32'h0,   0, 32'h0000_0010, 0, 0);
      vecs[7]  = mk(0, 0, 32'h0,        1, 32'h80,  0, 32'h0000_0010, 0, 1);
      vecs[8]  = mk(0, 0, 32'h0,        0, 32'h0,   0, 32'h0000_0010, 0, 0);
      vecs[9]  = mk(0, 0, 32'h0,        0, 32'h0,   1, 32'h0000_0010, 0, 0);
      vecs[10] = mk(0, 0, 32'h0,        0, 32'h0,   1, 32'h0000_0080, 1, 0);
      vecs[11] = mk(1, 0, 32'h0,        1, 32'h40,  1, 32'h0000_0084, 1, 1);
      vecs[12] = mk(0, 0, 32'h0,        0, 32'h0,   1, 32'h0000_0040, 1, 0);
      vecs[13] = mk(0, 1, 32'h20,       1, 32'h60,  1, 32'h0000_0044, 1, 1);
      vecs[14] = mk(0, 1, 32'h20,       0, 32'h0,   1, 32'h0000_0060, 1, 1);
      vecs[15] = mk(1, 1, 32'h100,      0, 32'h0,   1, 32'h0000_0020, 1, 0);
      vecs[16] = mk(0, 0, 32'h0,        0, 32'h0,   1, 32'h0000_0020, 1, 0);
      vecs[17] = mk(0, 1, 32'h200,      0, 32'h0,   0, 32'h0000_0024, 0, 1);
      vecs[18] = mk(0, 1, 32'h300,      0, 32'h0,   0, 32'h0000_0024, 0, 1);
      vecs[19] = mk(0, 0, 32'h0,        0, 32'h0,   1, 32'h0000_0024, 0, 0);
      vecs[20] = mk(0, 0, 32'h0,        0, 32'h0,   1, 32'h0000_0200, 1, 0);
      vecs[21] = mk(0, 0, 32'h0,        0, 32'h0,   0, 32'h0000_0204, 0, 0);
      vecs[22] = mk(0, 0, 32'h0,        1, 32'h500, 0, 32'h0000_0204, 0, 1);
      vecs[23] = mk(0, 0, 32'h0,        1, 32'h600, 0, 32'h0000_0204, 0, 1);
      vecs[24] = mk(0, 0, 32'h0,        0, 32'h0,   1, 32'h0000_0204, 0, 0);
      vecs[25] = mk(0, 0, 32'h0,        0, 32'h0,   1, 32'h0000_0600, 1, 0);
      vecs[26] = mk(0, 1, 32'hFFFF_FFFC, 0, 32'h0,  1, 32'h0000_0604, 1, 1);
      vecs[27] = mk(0, 0, 32'h0,        0, 32'h0,   1, 32'hFFFF_FFFC, 1, 0);
      vecs[28] = mk(0, 0, 32'h0,        0, 32'h0,   1, 32'h0000_0000, 1, 0);
      vecs[29] = mk(0, 0, 32'h0,        0, 32'h0,   0, 32'h0000_0004, 0, 0);
      vecs[30] = mk(0, 0, 32'h0,        0, 32'h0,   1, 32'h0000_0004, 1, 0);
      vecs[31] = mk(0, 0, 32'h0,        0, 32'h0,   1, 32'h0000_0008, 1, 0);

      imem_bus.imem_ready = 1'b1;
      imem_bus.imem_rdata = 32'hDEAD_BEEF;

      // Reset held: everything quiet even with a branch request present.
      repeat (2) @(posedge clk_i);
      #1 branch_taken_i = 1'b1; branch_target_i = 32'h40;
      #1;
      check("rst req", 32'(imem_bus.imem_req), 32'd0);
      check("rst addr", imem_bus.imem_addr, 32'h0);
      check("rst valid", 32'(fetch_valid_o), 32'd0);
      check("rst instr", instr_o, NOP);
      check("rst flush", 32'(if_flush_o), 32'd0);
      check("rst pc4", pc_plus4_o, 32'h0);
      branch_taken_i = 1'b0; branch_target_i = '0;
      @(posedge clk_i);
      #1 rst_i = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         rdata           = 32'hC0DE_0000 | 32'(i);
         pc_stall_i      = vecs[i].stall;
         jump_i          = vecs[i].jump;
         jump_target_i   = vecs[i].jt;
         branch_taken_i  = vecs[i].br;
         branch_target_i = vecs[i].bt;
         imem_bus.imem_ready = vecs[i].rdy;
         imem_bus.imem_rdata = rdata;
         e.idx   = i;
         e.addr  = vecs[i].exp_addr;
         e.valid = vecs[i].exp_valid;
         e.instr = vecs[i].exp_valid ? rdata : NOP;
         e.pc4   = vecs[i].exp_addr + 32'd4;
         e.flush = vecs[i].exp_flush;
         sb_q.push_back(e);
         @(posedge clk_i);
         #1;
      end

      // Reset asserted mid-WAIT: access abandoned, PC back to reset value.
      pc_stall_i = 1'b0; jump_i = 1'b0; branch_taken_i = 1'b0;
      imem_bus.imem_ready = 1'b0;
      @(posedge clk_i);
      #1;
      check("wait addr", imem_bus.imem_addr, 32'h0000_000C);
      check("wait valid", 32'(fetch_valid_o), 32'd0);
      $display("hand wait addr=%h valid=%0b", imem_bus.imem_addr, fetch_valid_o);
      #2 rst_i = 1'b0; branch_taken_i = 1'b1; branch_target_i = 32'h80;
      #1;
      check("mid rst req", 32'(imem_bus.imem_req), 32'd0);
      check("mid rst flush", 32'(if_flush_o), 32'd0);
      check("mid rst instr", instr_o, NOP);
      check("mid rst pc", dut.pc_reg, 32'h0);
      $display("hand reset req=%0b pc=%h", imem_bus.imem_req, dut.pc_reg);
      @(posedge clk_i);
      #1 rst_i = 1'b1; branch_taken_i = 1'b0; imem_bus.imem_ready = 1'b1;
      imem_bus.imem_rdata = 32'h1234_5678;
      @(negedge clk_i);
      check("post rst addr", imem_bus.imem_addr, 32'h0);
      check("post rst valid", 32'(fetch_valid_o), 32'd1);
      check("post rst instr", instr_o, 32'h1234_5678);
      $display("hand post-reset addr=%h valid=%0b", imem_bus.imem_addr, fetch_valid_o);
      @(negedge clk_i);
      check("post rst addr2", imem_bus.imem_addr, 32'h4);
      $display("hand post-reset addr=%h", imem_bus.imem_addr);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
